g_key_word: RTL and testbench



---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_sbox.sv | 11 +
 rtl/g_key_word.sv | 91 +++++++++
 tb/tb_g_key_word.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, Rcon lookup and g-function FSM states
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROT,
    SUB,
    RCON,
    OUT
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round 0 carries the round-10 constant (0x36) because the round counter wraps.
  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd2:    rc = 8'h01;
      4'd3:    rc = 8'h02;
      4'd4:    rc = 8'h04;
      4'd5:    rc = 8'h08;
      4'd6:    rc = 8'h10;
      4'd7:    rc = 8'h20;
      4'd8:    rc = 8'h40;
      4'd9:    rc = 8'h80;
      4'd10:   rc = 8'h1b;
      4'd0:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational FIPS-197 forward S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] sbox_i,
  output logic [7:0] sbox_o
);

  assign sbox_o = SBOX[sbox_i];

endmodule

// File: rtl/g_key_word.sv
// rtl/g_key_word.sv - multi-cycle AES-128 key-schedule g function with one shared S-box
module g_key_word
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] inputVal,
  input  logic [3:0]  roundNum,
  output logic [31:0] finalOutputVal,
  output logic        done
);

  state_e      state_q;
  logic [31:0] work_q;
  logic [3:0]  round_q;
  logic [1:0]  byte_idx_q;
  logic        phase_q;
  logic [7:0]  sbox_in_q;
  logic [31:0] final_q;
  logic        done_q;

  logic [1:0]  byte_sel;
  logic [7:0]  sbox_out;

  // Byte index 0 addresses the most significant byte, so bytes go MSB first.
  assign byte_sel = 2'd3 - byte_idx_q;

  aes_sbox u_sbox (
    .sbox_i (sbox_in_q),
    .sbox_o (sbox_out)
  );

  // Control FSM and datapath: rotate, substitute one byte per two cycles, add Rcon, publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      round_q    <= '0;
      byte_idx_q <= '0;
      phase_q    <= 1'b0;
      sbox_in_q  <= '0;
      final_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            work_q  <= inputVal;
            round_q <= roundNum;
            state_q <= ROT;
          end
        end
        ROT: begin
          work_q     <= {work_q[23:0], work_q[31:24]};
          byte_idx_q <= 2'd0;
          phase_q    <= 1'b0;
          state_q    <= SUB;
        end
        SUB: begin
          if (!phase_q) begin
            sbox_in_q <= work_q[{byte_sel, 3'b000} +: 8];
            phase_q   <= 1'b1;
          end else begin
            work_q[{byte_sel, 3'b000} +: 8] <= sbox_out;
            phase_q    <= 1'b0;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q <= RCON;
            end
          end
        end
        RCON: begin
          work_q[31:24] <= work_q[31:24] ^ rcon_of(round_q);
          state_q       <= OUT;
        end
        OUT: begin
          final_q <= work_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign finalOutputVal = final_q;
  assign done           = done_q;

endmodule

// File: tb/tb_g_key_word.sv
// tb/tb_g_key_word.sv - self-checking bench for g_key_word with a GF(2^8) reference model
module tb_g_key_word;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] inputVal;
  logic [3:0]  roundNum;
  logic [31:0] finalOutputVal;
  logic        done;

  int n_checks;
  int n_fail;

  g_key_word dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .inputVal       (inputVal),
    .roundNum       (roundNum),
    .finalOutputVal (finalOutputVal),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: S-box derived from the field inverse and affine map, not from a table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_model(input logic [3:0] rn);
    logic [7:0] r;
    int         steps;
    if (rn == 4'd0) steps = 9;
    else if (rn >= 4'd2 && rn <= 4'd10) steps = int'(rn) - 2;
    else return 8'h00;
    r = 8'h01;
    for (int i = 0; i < steps; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [31:0] g_model(input logic [31:0] w, input logic [3:0] rn);
    logic [31:0] r;
    logic [31:0] s;
    r = {w[23:0], w[31:24]};
    for (int b = 0; b < 4; b++) s[b*8 +: 8] = sbox_model(r[b*8 +: 8]);
    s[31:24] = s[31:24] ^ rcon_model(rn);
    return s;
  endfunction

  // Launch at P0 and return the edge index at which done was first seen high (0 on timeout).
  task automatic run_op(input logic [31:0] w, input logic [3:0] rn, output int lat);
    @(negedge clk);
    inputVal = w;
    roundNum = rn;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] w, input logic [3:0] rn,
                          input logic [31:0] exp);
    int lat;
    run_op(w, rn, lat);
    n_checks++;
    if (lat !== 11) begin
      n_fail++;
      $display("FAIL %s latency: got %0d, expected 11", name, lat);
    end
    n_checks++;
    if (finalOutputVal !== exp) begin
      n_fail++;
      $display("FAIL %s value: got %08h, expected %08h", name, finalOutputVal, exp);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done width: done still %b one cycle later, expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    enable   = 1'b0;
    inputVal = '0;
    roundNum = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (finalOutputVal !== 32'h0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out=%08h done=%b, expected 00000000/0", finalOutputVal, done);
    end
  endtask

  task automatic test_directed();
    check_op("vec_aa_r2",  32'hAAAAAAAA, 4'd2,  32'hADACACAC);
    check_op("vec_f0_r3",  32'hF045FF8B, 4'd3,  32'h6C163D8C);
    check_op("vec_ff_r4",  32'hFFFFFFFF, 4'd4,  32'h12161616);
    check_op("vec_00_r5",  32'h00000000, 4'd5,  32'h6B636363);
    check_op("vec_12_r6",  32'h12345678, 4'd6,  32'h08B1BCC9);
    check_op("vec_87_r7",  32'h87654321, 4'd7,  32'h6D1AFD17);
    check_op("vec_a5_r8",  32'hA5F3DF8B, 4'd8,  32'h4D9E3D06);
    check_op("vec_66_r9",  32'h66E5F9B9, 4'd9,  32'h59995633);
    check_op("vec_00_r10", 32'h00C6F267, 4'd10, 32'hAF898563);
    check_op("vec_f1_r0",  32'hF1CD6FEE, 4'd0,  32'h8BA828A1);
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [3:0]  rn;
    for (int i = 0; i < 24; i++) begin
      w  = $urandom;
      rn = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      check_op($sformatf("rand%0d", i), w, rn, g_model(w, rn));
    end
  endtask

  task automatic test_enable_busy();
    logic [31:0] w;
    logic [3:0]  rn;
    int          lat;
    w  = $urandom;
    rn = 4'd9;
    @(negedge clk);
    inputVal = w;
    roundNum = rn;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    lat    = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        inputVal = ~w;
        roundNum = 4'd1;
        enable   = 1'b1;
      end else if (k == 4) begin
        enable = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat !== 11) begin
      n_fail++;
      $display("FAIL busy_enable latency: got %0d, expected 11", lat);
    end
    n_checks++;
    if (finalOutputVal !== g_model(w, rn)) begin
      n_fail++;
      $display("FAIL busy_enable value: got %08h, expected %08h", finalOutputVal, g_model(w, rn));
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_enable restart: done=%b, expected 0 (no second op)", done);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    inputVal = $urandom;
    roundNum = 4'd4;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid done: pulses=%0d, expected 0", seen);
    end
    n_checks++;
    if (finalOutputVal !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid value: got %08h, expected 00000000", finalOutputVal);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1;
    logic [31:0] w2;
    int          lat1;
    int          lat2;
    w1 = $urandom;
    w2 = $urandom;
    @(negedge clk);
    inputVal = w1;
    roundNum = 4'd10;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    inputVal = w2;
    roundNum = 4'd0;
    lat1     = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat1 = k;
        break;
      end
    end
    n_checks++;
    if (lat1 !== 11 || finalOutputVal !== g_model(w1, 4'd10)) begin
      n_fail++;
      $display("FAIL b2b first: lat=%0d out=%08h, expected 11/%08h", lat1, finalOutputVal,
               g_model(w1, 4'd10));
    end
    @(posedge clk);
    #1;
    enable = 1'b0;
    inputVal = $urandom;
    lat2 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat2 = k;
        break;
      end
    end
    n_checks++;
    if (lat2 !== 11 || finalOutputVal !== g_model(w2, 4'd0)) begin
      n_fail++;
      $display("FAIL b2b second: lat=%0d out=%08h, expected 11/%08h", lat2, finalOutputVal,
               g_model(w2, 4'd0));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_enable_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
